// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake plus the registered micro-op bundle handed on to execute.
interface decode_stage_if;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        fetch_stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [3:0]  out_cond;
  logic [2:0]  out_class;
  logic [3:0]  out_opcode;
  logic        out_set_flags;
  logic [3:0]  out_rn;
  logic [3:0]  out_rd;
  logic [3:0]  out_rm;
  logic [3:0]  out_rs;
  logic [31:0] out_imm;
  logic        out_imm_valid;
  logic        out_link;
  logic        out_load;
  logic [3:0]  out_xfer_reg;
  logic [5:0]  out_xfer_offset;
  logic        out_multi_first;
  logic        out_multi_last;
  logic        out_undefined;

  modport slave (
    input  stall, flush, in_valid, in_pc, in_instr,
    output fetch_stall, out_valid, out_pc, out_cond, out_class, out_opcode,
           out_set_flags, out_rn, out_rd, out_rm, out_rs, out_imm, out_imm_valid,
           out_link, out_load, out_xfer_reg, out_xfer_offset, out_multi_first,
           out_multi_last, out_undefined
  );

  modport master (
    output stall, flush, in_valid, in_pc, in_instr,
    input  fetch_stall, out_valid, out_pc, out_cond, out_class, out_opcode,
           out_set_flags, out_rn, out_rd, out_rm, out_rs, out_imm, out_imm_valid,
           out_link, out_load, out_xfer_reg, out_xfer_offset, out_multi_first,
           out_multi_last, out_undefined
  );
endinterface

// File: rtl/decode_stage.sv
// ARM7 decode stage: classifies one instruction per cycle into a registered bundle and
// expands LDM/STM register lists into one micro-op per listed register.
module decode_stage (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  typedef enum logic {IDLE, MULTI} state_e;

  typedef enum logic [2:0] {
    CLS_DP     = 3'd0,
    CLS_MUL    = 3'd1,
    CLS_SDT    = 3'd2,
    CLS_BDT    = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_SWI    = 3'd5,
    CLS_UNDEF  = 3'd6
  } class_e;

  state_e      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [3:0]  ord_q, ord_d;

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cond_q, cond_d;
  class_e      cls_q, cls_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        sf_q, sf_d;
  logic [3:0]  rn_q, rn_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  rm_q, rm_d;
  logic [3:0]  rs_q, rs_d;
  logic [31:0] imm_q, imm_d;
  logic        immv_q, immv_d;
  logic        link_q, link_d;
  logic        load_q, load_d;
  logic [3:0]  xreg_q, xreg_d;
  logic [5:0]  xoff_q, xoff_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        undef_q, undef_d;

  logic [31:0] instr;
  class_e      dec_cls;
  logic [31:0] dec_imm;
  logic        dec_immv;
  logic [31:0] imm8_w;
  logic [4:0]  rot_amt;
  logic [31:0] rot_imm;
  logic [15:0] dec_list;
  logic [15:0] dec_rest;
  logic [3:0]  dec_low;
  logic [15:0] seq_rest;
  logic [3:0]  seq_low;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (v[i-1]) r = 4'(i - 1);
    end
    return r;
  endfunction

  assign instr = bus.in_instr;

  always_comb begin
    dec_cls = CLS_UNDEF;
    unique case (instr[27:25])
      3'b000:  dec_cls = (instr[7:4] == 4'b1001 && instr[24:22] == 3'b000) ? CLS_MUL : CLS_DP;
      3'b001:  dec_cls = CLS_DP;
      3'b010:  dec_cls = CLS_SDT;
      3'b011:  dec_cls = instr[4] ? CLS_UNDEF : CLS_SDT;
      3'b100:  dec_cls = CLS_BDT;
      3'b101:  dec_cls = CLS_BRANCH;
      default: dec_cls = (instr[27:24] == 4'hF) ? CLS_SWI : CLS_UNDEF;
    endcase
  end

  // Rotate-right built from two shifts; a zero rotate makes the left shift vanish.
  assign imm8_w  = {24'b0, instr[7:0]};
  assign rot_amt = {instr[11:8], 1'b0};
  assign rot_imm = (imm8_w >> rot_amt) | (imm8_w << (6'd32 - {1'b0, rot_amt}));

  always_comb begin
    dec_imm  = '0;
    dec_immv = 1'b0;
    if (dec_cls == CLS_DP && instr[25]) begin
      dec_imm  = rot_imm;
      dec_immv = 1'b1;
    end else if (dec_cls == CLS_SDT && !instr[25]) begin
      dec_imm  = {20'b0, instr[11:0]};
      dec_immv = 1'b1;
    end else if (dec_cls == CLS_BRANCH) begin
      dec_imm  = {{6{instr[23]}}, instr[23:0], 2'b00};
      dec_immv = 1'b1;
    end
  end

  assign dec_list = instr[15:0];
  assign dec_low  = lowest_set(dec_list);
  assign dec_rest = dec_list & (dec_list - 16'd1);
  assign seq_low  = lowest_set(mask_q);
  assign seq_rest = mask_q & (mask_q - 16'd1);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ord_d    = ord_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    cond_d   = cond_q;
    cls_d    = cls_q;
    opcode_d = opcode_q;
    sf_d     = sf_q;
    rn_d     = rn_q;
    rd_d     = rd_q;
    rm_d     = rm_q;
    rs_d     = rs_q;
    imm_d    = imm_q;
    immv_d   = immv_q;
    link_d   = link_q;
    load_d   = load_q;
    xreg_d   = xreg_q;
    xoff_d   = xoff_q;
    first_d  = first_q;
    last_d   = last_q;
    undef_d  = undef_q;

    if (bus.flush) begin
      valid_d = 1'b0;
      state_d = IDLE;
      mask_d  = '0;
      ord_d   = '0;
    end else if (!bus.stall) begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            valid_d  = 1'b1;
            pc_d     = bus.in_pc;
            cond_d   = instr[31:28];
            cls_d    = dec_cls;
            opcode_d = instr[24:21];
            sf_d     = instr[20];
            rn_d     = instr[19:16];
            rd_d     = instr[15:12];
            rm_d     = instr[3:0];
            rs_d     = instr[11:8];
            imm_d    = dec_imm;
            immv_d   = dec_immv;
            link_d   = (dec_cls == CLS_BRANCH) && instr[24];
            load_d   = (dec_cls == CLS_SDT || dec_cls == CLS_BDT) && instr[20];
            xreg_d   = '0;
            xoff_d   = '0;
            first_d  = 1'b1;
            last_d   = 1'b1;
            undef_d  = (dec_cls == CLS_UNDEF);
            if (dec_cls == CLS_BDT) begin
              if (dec_list == '0) begin
                undef_d = 1'b1;
              end else begin
                xreg_d = dec_low;
                if (dec_rest != '0) begin
                  last_d  = 1'b0;
                  mask_d  = dec_rest;
                  ord_d   = 4'd1;
                  state_d = MULTI;
                end
              end
            end
          end else begin
            valid_d = 1'b0;
          end
        end
        MULTI: begin
          valid_d = 1'b1;
          xreg_d  = seq_low;
          xoff_d  = {ord_q, 2'b00};
          first_d = 1'b0;
          mask_d  = seq_rest;
          ord_d   = ord_q + 4'd1;
          last_d  = 1'b0;
          if (seq_rest == '0) begin
            last_d  = 1'b1;
            ord_d   = '0;
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      ord_q    <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      cond_q   <= '0;
      cls_q    <= CLS_DP;
      opcode_q <= '0;
      sf_q     <= 1'b0;
      rn_q     <= '0;
      rd_q     <= '0;
      rm_q     <= '0;
      rs_q     <= '0;
      imm_q    <= '0;
      immv_q   <= 1'b0;
      link_q   <= 1'b0;
      load_q   <= 1'b0;
      xreg_q   <= '0;
      xoff_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      undef_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ord_q    <= ord_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      cond_q   <= cond_d;
      cls_q    <= cls_d;
      opcode_q <= opcode_d;
      sf_q     <= sf_d;
      rn_q     <= rn_d;
      rd_q     <= rd_d;
      rm_q     <= rm_d;
      rs_q     <= rs_d;
      imm_q    <= imm_d;
      immv_q   <= immv_d;
      link_q   <= link_d;
      load_q   <= load_d;
      xreg_q   <= xreg_d;
      xoff_q   <= xoff_d;
      first_q  <= first_d;
      last_q   <= last_d;
      undef_q  <= undef_d;
    end
  end

  assign bus.fetch_stall     = bus.stall | (state_q == MULTI);
  assign bus.out_valid       = valid_q;
  assign bus.out_pc          = pc_q;
  assign bus.out_cond        = cond_q;
  assign bus.out_class       = cls_q;
  assign bus.out_opcode      = opcode_q;
  assign bus.out_set_flags   = sf_q;
  assign bus.out_rn          = rn_q;
  assign bus.out_rd          = rd_q;
  assign bus.out_rm          = rm_q;
  assign bus.out_rs          = rs_q;
  assign bus.out_imm         = imm_q;
  assign bus.out_imm_valid   = immv_q;
  assign bus.out_link        = link_q;
  assign bus.out_load        = load_q;
  assign bus.out_xfer_reg    = xreg_q;
  assign bus.out_xfer_offset = xoff_q;
  assign bus.out_multi_first = first_q;
  assign bus.out_multi_last  = last_q;
  assign bus.out_undefined   = undef_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against a queue-based micro-op model.
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  cond;
    logic [2:0]  cls;
    logic [3:0]  opcode;
    logic        sf;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [31:0] imm;
    logic        immv;
    logic        link;
    logic        load;
    logic [3:0]  xreg;
    logic [5:0]  xoff;
    logic        first;
    logic        last;
    logic        undef;
  } bundle_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  bundle_t cur;
  bundle_t pend[$];

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected micro-ops of one instruction, appended to pend in issue order.
  function automatic void expand(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    int      s;
    int      cnt;
    int      n;
    logic [31:0] v;
    b       = '0;
    b.valid = 1'b1;
    b.pc    = pc;
    b.cond  = ins[31:28];
    b.opcode = ins[24:21];
    b.sf    = ins[20];
    b.rn    = ins[19:16];
    b.rd    = ins[15:12];
    b.rm    = ins[3:0];
    b.rs    = ins[11:8];
    b.first = 1'b1;
    b.last  = 1'b1;
    if (ins[27:24] == 4'hF)                                   b.cls = 3'd5;
    else if (ins[27:26] == 2'b11)                             b.cls = 3'd6;
    else if (ins[27:25] == 3'b101)                            b.cls = 3'd4;
    else if (ins[27:25] == 3'b100)                            b.cls = 3'd3;
    else if (ins[27:25] == 3'b011 && ins[4])                  b.cls = 3'd6;
    else if (ins[27:26] == 2'b01)                             b.cls = 3'd2;
    else if (ins[27:22] == 6'd0 && ins[7:4] == 4'b1001)       b.cls = 3'd1;
    else                                                      b.cls = 3'd0;
    if (b.cls == 3'd0 && ins[25]) begin
      v = {24'b0, ins[7:0]};
      for (int k = 0; k < 2 * int'(ins[11:8]); k++) v = {v[0], v[31:1]};
      b.imm = v;
      b.immv = 1'b1;
    end else if (b.cls == 3'd2 && !ins[25]) begin
      b.imm = {20'b0, ins[11:0]};
      b.immv = 1'b1;
    end else if (b.cls == 3'd4) begin
      s = $signed(ins[23:0]);
      b.imm = s * 4;
      b.immv = 1'b1;
    end
    b.link  = (b.cls == 3'd4) && ins[24];
    b.load  = (b.cls == 3'd2 || b.cls == 3'd3) && ins[20];
    b.undef = (b.cls == 3'd6);
    if (b.cls == 3'd3) begin
      cnt = $countones(ins[15:0]);
      if (cnt == 0) begin
        b.undef = 1'b1;
        pend.push_back(b);
      end else begin
        n = 0;
        for (int r = 0; r < 16; r++) begin
          if (ins[r]) begin
            b.xreg  = 4'(r);
            b.xoff  = 6'(n * 4);
            b.first = (n == 0);
            b.last  = (n == cnt - 1);
            pend.push_back(b);
            n++;
          end
        end
      end
    end else begin
      pend.push_back(b);
    end
  endfunction

  function automatic void model_edge();
    if (bus.flush) begin
      cur.valid = 1'b0;
      pend.delete();
    end else if (!bus.stall) begin
      if (pend.size() > 0) begin
        cur = pend.pop_front();
      end else if (bus.in_valid) begin
        expand(bus.in_instr, bus.in_pc);
        cur = pend.pop_front();
      end else begin
        cur.valid = 1'b0;
      end
    end
  endfunction

  function automatic bundle_t obs();
    bundle_t b;
    b.valid  = bus.out_valid;
    b.pc     = bus.out_pc;
    b.cond   = bus.out_cond;
    b.cls    = bus.out_class;
    b.opcode = bus.out_opcode;
    b.sf     = bus.out_set_flags;
    b.rn     = bus.out_rn;
    b.rd     = bus.out_rd;
    b.rm     = bus.out_rm;
    b.rs     = bus.out_rs;
    b.imm    = bus.out_imm;
    b.immv   = bus.out_imm_valid;
    b.link   = bus.out_link;
    b.load   = bus.out_load;
    b.xreg   = bus.out_xfer_reg;
    b.xoff   = bus.out_xfer_offset;
    b.first  = bus.out_multi_first;
    b.last   = bus.out_multi_last;
    b.undef  = bus.out_undefined;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $display("FAIL %s: observed %h expected %h", tag, o, e);
      $error("check %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_bundle"}, 128'(obs()), 128'(cur));
    chk({tag, "_fstall"}, 128'(bus.fetch_stall), 128'(bus.stall | (pend.size() != 0)));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic fl);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = ins;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  initial begin
    logic [31:0] ins;
    int          r;
    tests = 0;
    fails = 0;
    cur   = '0;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #7;
    chk_model("reset");
    chk("reset_first", 128'(bus.out_multi_first), 128'(0));
    #1 rst_n = 1'b1;

    drive(1'b1, 32'h0, 32'hE3A004FF, 1'b0, 1'b0);
    tick("dp_imm");
    chk("dp_imm_val", 128'(bus.out_imm), 128'(32'hFF000000));
    chk("dp_class", 128'(bus.out_class), 128'(0));
    chk("dp_opcode", 128'(bus.out_opcode), 128'(4'b1101));
    chk("dp_fl", 128'({bus.out_multi_first, bus.out_multi_last, bus.out_imm_valid}), 128'(3'b111));

    drive(1'b1, 32'h100, 32'hEAFFFFFE, 1'b0, 1'b0);
    tick("b_back");
    chk("b_back_imm", 128'({bus.out_class, bus.out_imm, bus.out_link}), 128'({3'd4, 32'hFFFFFFF8, 1'b0}));
    drive(1'b1, 32'h104, 32'hEB000001, 1'b0, 1'b0);
    tick("bl_fwd");
    chk("bl_fwd_imm", 128'({bus.out_imm, bus.out_link}), 128'({32'h4, 1'b1}));

    drive(1'b1, 32'h108, 32'hE8918005, 1'b0, 1'b0);
    tick("ldm_op1");
    chk("ldm_op1_x", 128'({bus.out_xfer_reg, bus.out_xfer_offset, bus.out_multi_first, bus.out_load, bus.fetch_stall}),
        128'({4'd0, 6'd0, 1'b1, 1'b1, 1'b1}));
    drive(1'b1, 32'h10C, 32'hE3A004FF, 1'b0, 1'b0);
    tick("ldm_op2");
    chk("ldm_op2_x", 128'({bus.out_xfer_reg, bus.out_xfer_offset, bus.fetch_stall}), 128'({4'd2, 6'd4, 1'b1}));
    tick("ldm_op3");
    chk("ldm_op3_x", 128'({bus.out_xfer_reg, bus.out_xfer_offset, bus.out_multi_last, bus.fetch_stall}),
        128'({4'd15, 6'd8, 1'b1, 1'b0}));
    tick("after_ldm");
    chk("after_ldm_pc", 128'({bus.out_valid, bus.out_pc}), 128'({1'b1, 32'h10C}));

    drive(1'b1, 32'h200, 32'hE8918005, 1'b0, 1'b0);
    tick("stl_op1");
    tick("stl_op2");
    drive(1'b1, 32'h204, 32'hE3A004FF, 1'b1, 1'b0);
    tick("stl_hold1");
    tick("stl_hold2");
    chk("stl_held", 128'({bus.out_valid, bus.out_xfer_reg, bus.out_xfer_offset}), 128'({1'b1, 4'd2, 6'd4}));
    drive(1'b1, 32'h204, 32'hE3A004FF, 1'b0, 1'b0);
    tick("stl_op3");
    chk("stl_op3_x", 128'({bus.out_xfer_reg, bus.out_xfer_offset}), 128'({4'd15, 6'd8}));
    tick("stl_next");

    drive(1'b1, 32'h300, 32'hE8918005, 1'b0, 1'b0);
    tick("fl_op1");
    tick("fl_op2");
    drive(1'b1, 32'h304, 32'hE3A004FF, 1'b0, 1'b1);
    tick("fl_kill");
    chk("fl_kill_v", 128'({bus.out_valid, bus.fetch_stall}), 128'(2'b00));
    drive(1'b1, 32'h304, 32'hE3A004FF, 1'b0, 1'b0);
    tick("fl_next");
    chk("fl_next_pc", 128'({bus.out_valid, bus.out_pc}), 128'({1'b1, 32'h304}));

    drive(1'b1, 32'h400, 32'hE6000010, 1'b0, 1'b0);
    tick("undef");
    chk("undef_x", 128'({bus.out_class, bus.out_undefined}), 128'({3'd6, 1'b1}));
    drive(1'b1, 32'h404, 32'hE8910000, 1'b0, 1'b0);
    tick("ldm_empty");
    chk("ldm_empty_x", 128'({bus.out_undefined, bus.out_multi_first, bus.out_multi_last, bus.out_xfer_reg}),
        128'({3'b111, 4'd0}));

    drive(1'b1, 32'h500, 32'hE8918005, 1'b0, 1'b0);
    tick("rst_op1");
    #2 rst_n = 1'b0;
    #1;
    cur = '0;
    pend.delete();
    chk_model("rst_mid");
    #3 rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick("rst_idle");

    for (int c = 0; c < 600; c++) begin
      ins = $urandom();
      r = $urandom_range(0, 7);
      if (r == 0) begin
        ins[27:22] = 6'b000000;
        ins[7:4]   = 4'b1001;
      end else if (r <= 2) begin
        ins[27:25] = 3'b100;
        if ($urandom_range(0, 5) == 0) ins[15:0] = '0;
        else ins[15:0] = 16'($urandom()) & 16'($urandom());
      end
      drive($urandom_range(0, 4) != 0, $urandom(), ins,
            $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the ARM7 core: it sits directly downstream of the fetch stage and upstream of execute. It accepts one (pc, instruction) pair per cycle, classifies the ARM instruction, extracts register fields and immediates into a registered output bundle, and expands block transfers (LDM/STM) into one micro-op per listed register. While a block transfer is being expanded, it holds fetch off.

## Interface
- No parameters. Widths are fixed: 32-bit datapath, 4-bit register indices.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold; output bundle and sequencer state freeze.
- flush  in  1  kill: invalidates output and aborts any expansion; has priority over stall.
- in_valid  in  1  in_pc/in_instr hold a fetched instruction.
- in_pc  in  32  address of in_instr.
- in_instr  in  32  raw ARM instruction.
- fetch_stall  out  1  combinational hold request to fetch: stall OR (state==MULTI).
- out_valid  out  1  output bundle is a live micro-op.
- out_pc  out  32  pc of the originating instruction.
- out_cond  out  4  instr[31:28].
- out_class  out  3  0 DP, 1 MUL, 2 SDT, 3 BDT, 4 BRANCH, 5 SWI, 6 UNDEF.
- out_opcode  out  4  instr[24:21].
- out_set_flags  out  1  instr[20].
- out_rn / out_rd / out_rm / out_rs  out  4 each  instr[19:16] / [15:12] / [3:0] / [11:8].
- out_imm  out  32  decoded immediate (see Operation).
- out_imm_valid  out  1  out_imm is the operand.
- out_link  out  1  BL (BRANCH with instr[24]=1).
- out_load  out  1  instr[20] for SDT/BDT, else 0.
- out_xfer_reg  out  4  BDT: register for this micro-op.
- out_xfer_offset  out  6  BDT: ordinal × 4 (0..60).
- out_multi_first / out_multi_last  out  1 each  first/last micro-op of a BDT; both are 1 for every non-BDT op.
- out_undefined  out  1  UNDEF class, or BDT with empty register list.

## Operation
- Accept condition: in_valid & !stall & !flush & state==IDLE. On accept, every output field loads from in_instr/in_pc. A cycle with no accept and no stall loads out_valid=0.
- Classification on instr[27:25]:
  - 000 with [7:4]=1001 and [24:22]=000 → MUL; otherwise 000/001 → DP.
  - 010 → SDT. 011 → SDT if [4]=0, UNDEF if [4]=1.
  - 100 → BDT. 101 → BRANCH.
  - 11x → SWI if [27:24]=1111, else UNDEF.
- DP with [25]=1: out_imm = zero-extended imm8 rotated right by 2×instr[11:8]; out_imm_valid=1.
- SDT with [25]=0: out_imm = zero-extended instr[11:0]; out_imm_valid=1.
- BRANCH: out_imm = sign-extended instr[23:0] << 2 (32-bit wrap); out_imm_valid=1.
- In all other cases out_imm=0 and out_imm_valid=0.
- BDT sequencer, states IDLE and MULTI:
  - On accepting a BDT with list L: emit the lowest set bit of L at offset 0, first=1.
  - If popcount(L)=1: last=1 and stay in IDLE.
  - If popcount(L)>1: remaining mask ← L minus that bit, ordinal ← 1, go to MULTI.
  - In MULTI, on each !stall cycle: emit the lowest set bit of the mask at offset ordinal×4, clear that bit, increment ordinal. All non-xfer fields keep their values.
  - When the mask becomes empty, last=1 and return to IDLE.
  - L=0: a single op with out_undefined=1, first=last=1, xfer_reg=0.
- Flush: out_valid←0, state←IDLE, mask←0, ordinal←0. Any instruction presented in the same cycle is discarded.

## Timing
- Latency 1: an instruction accepted at edge k is visible on the outputs after edge k.
- A BDT with N registers occupies N consecutive non-stalled cycles. fetch_stall is high for the last N−1 of them, so the next instruction is accepted on the cycle the last micro-op is registered.
- stall freezes all registers, including mask and ordinal, indefinitely.
- Reset (asynchronous, any time including mid-MULTI): every output 0, state IDLE, mask 0. fetch_stall then follows stall only.

## Test plan
- DP immediate: 0xE3A004FF → out_class=0, rd=0, opcode=1101, imm=0xFF000000, imm_valid=1, first=last=1, one cycle later.
- Branch: 0xEAFFFFFE at pc 0x100 → class=4, imm=0xFFFFFFF8, link=0. Then 0xEB000001 → imm=0x4, link=1.
- LDM: 0xE8918005 → three ops on consecutive cycles: xfer_reg 0/2/15, offsets 0/4/8, first on op 1, last on op 3, load=1, fetch_stall high for 2 cycles.
- Stall inserted between ops 2 and 3 → op 2 held stable. Once released, op 3 appears with reg 15, offset 8.
- Flush asserted during op 2 of the same LDM → out_valid=0 next cycle, fetch_stall=0. The next instruction is accepted on the following cycle.
- Undefined and reset: 0xE6000010 → class=6, undefined=1. LDM with list 0 → undefined=1. rst_n pulsed low mid-MULTI → all outputs 0 immediately.
